// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and digit limits for the stopwatch core.
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t        DIG_MAX      = 4'd9;
    localparam bcd_t        SEC_T_MAX    = 4'd5;
    localparam logic [23:0] MAX_TIME_BCD = 24'h995999;

endpackage

// File: rtl/stopwatch_if.sv
// stopwatch_if: command/tic inputs and display/status outputs of the stopwatch core.
interface stopwatch_if;

    logic        i_tic;
    logic        i_start_stop;
    logic        i_clear;
    logic        i_lap;
    logic [23:0] o_time_bcd;
    logic        o_running;
    logic        o_ovf;
    logic        o_cs_tick;

    modport master (
        output i_tic, i_start_stop, i_clear, i_lap,
        input  o_time_bcd, o_running, o_ovf, o_cs_tick
    );

    modport slave (
        input  i_tic, i_start_stop, i_clear, i_lap,
        output o_time_bcd, o_running, o_ovf, o_cs_tick
    );

endinterface

// File: rtl/stopwatch_bcd_digit.sv
// bcd_digit: one BCD counter stage 0..LIMIT with ripple-free carry-out for the stopwatch chain.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter bcd_t LIMIT = DIG_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic carry
);

    bcd_t r_q;

    always_ff @(posedge clk)
        r_q <= (!rst || clr) ? '0 : inc ? ((r_q == LIMIT) ? '0 : r_q + 4'd1) : r_q;

    assign q     = r_q;
    assign carry = inc && (r_q == LIMIT);

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: MM:SS.CC stopwatch with start/stop/clear FSM and tic prescaler.
// Optional lap display hold is enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TIC_DIV    = 10,
    parameter bit SAT_AT_MAX = 1'b1
) (
    input logic        clk,
    input logic        rst,
    stopwatch_if.slave sw
);

    localparam int            PW       = (TIC_DIV > 1) ? $clog2(TIC_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TIC_DIV - 1);

    sw_state_t     r_state;
    sw_state_t     w_next;
    logic [PW-1:0] r_pre;
    logic          r_ovf;
    logic          r_cs_tick;
    logic          w_cnt;
    logic          w_inc;
    logic          w_sat;
    logic          w_step;
    logic          w_at_max;
    logic [5:0]    w_carry;
    bcd_t          w_cs_u, w_cs_t, w_sec_u, w_sec_t, w_min_u, w_min_t;
    logic [23:0]   w_live;

    always_ff @(posedge clk)
        r_state <= !rst ? IDLE : w_next;

    // A saturating increment at 99:59.99 is swallowed: digits hold and no cs_tick.
    always_comb begin
        w_next = r_state;
        if (sw.i_clear)
            w_next = IDLE;
        else if (sw.i_start_stop)
            w_next = (r_state == RUN) ? PAUSE : RUN;
        w_cnt  = (r_state == RUN) && sw.i_tic && !sw.i_clear;
        w_inc  = w_cnt && (r_pre == PRE_LAST);
        w_sat  = w_inc && w_at_max && SAT_AT_MAX;
        w_step = w_inc && !w_sat;
    end

    always_ff @(posedge clk)
        r_pre <= (!rst || sw.i_clear) ? '0 : !w_cnt ? r_pre : (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;

    always_ff @(posedge clk) begin
        r_ovf     <= (!rst || sw.i_clear) ? 1'b0 : (r_ovf || w_sat || w_carry[5]);
        r_cs_tick <= rst && w_step;
    end

    bcd_digit #(.LIMIT(DIG_MAX)) u_cs_u (
        .clk(clk), .rst(rst), .clr(sw.i_clear), .inc(w_step), .q(w_cs_u), .carry(w_carry[0])
    );
    bcd_digit #(.LIMIT(DIG_MAX)) u_cs_t (
        .clk(clk), .rst(rst), .clr(sw.i_clear), .inc(w_carry[0]), .q(w_cs_t), .carry(w_carry[1])
    );
    bcd_digit #(.LIMIT(DIG_MAX)) u_sec_u (
        .clk(clk), .rst(rst), .clr(sw.i_clear), .inc(w_carry[1]), .q(w_sec_u), .carry(w_carry[2])
    );
    bcd_digit #(.LIMIT(SEC_T_MAX)) u_sec_t (
        .clk(clk), .rst(rst), .clr(sw.i_clear), .inc(w_carry[2]), .q(w_sec_t), .carry(w_carry[3])
    );
    bcd_digit #(.LIMIT(DIG_MAX)) u_min_u (
        .clk(clk), .rst(rst), .clr(sw.i_clear), .inc(w_carry[3]), .q(w_min_u), .carry(w_carry[4])
    );
    bcd_digit #(.LIMIT(DIG_MAX)) u_min_t (
        .clk(clk), .rst(rst), .clr(sw.i_clear), .inc(w_carry[4]), .q(w_min_t), .carry(w_carry[5])
    );

    assign w_live       = {w_min_t, w_min_u, w_sec_t, w_sec_u, w_cs_t, w_cs_u};
    assign w_at_max     = (w_live == MAX_TIME_BCD);
    assign sw.o_running = (r_state == RUN);
    assign sw.o_ovf     = r_ovf;
    assign sw.o_cs_tick = r_cs_tick;

`ifdef STOPWATCH_LAP_HOLD_EN
    logic        r_hold;
    logic [23:0] r_snap;

    // Entering PAUSE releases the hold even if lap arrives in the same cycle.
    always_ff @(posedge clk)
        r_hold <= (!rst || sw.i_clear) ? 1'b0 :
                  (r_state != RUN) ? r_hold :
                  sw.i_start_stop ? 1'b0 :
                  sw.i_lap ? !r_hold : r_hold;

    always_ff @(posedge clk)
        r_snap <= (r_state == RUN && sw.i_lap && !r_hold) ? w_live : r_snap;

    assign sw.o_time_bcd = r_hold ? r_snap : w_live;
`else
    logic w_unused_lap;

    assign w_unused_lap  = sw.i_lap;
    assign sw.o_time_bcd = w_live;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed + random bench for saturating and wrapping stopwatch builds.
// Define STOPWATCH_LAP_HOLD_EN to also exercise the lap hold.
module tb_stopwatch_ctrl;

    localparam int TIC_DIV = 10;
    localparam int MAX_CS  = 599999;
`ifdef STOPWATCH_LAP_HOLD_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] pv;
    int          n_chk   = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_ticks = 0;

    // reference model: elapsed time as a plain count of centiseconds
    int m_mode;
    bit m_hold;
    int m_cs[2];
    int m_pre[2];
    int m_snap[2];
    bit m_ovf[2];
    bit m_tick[2];

    stopwatch_if sw_s ();
    stopwatch_if sw_w ();

    stopwatch_ctrl #(.TIC_DIV(TIC_DIV), .SAT_AT_MAX(1'b1)) dut_s (.clk(clk), .rst(rst), .sw(sw_s));
    stopwatch_ctrl #(.TIC_DIV(TIC_DIV), .SAT_AT_MAX(1'b0)) dut_w (.clk(clk), .rst(rst), .sw(sw_w));

    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic int to_cs(input logic [23:0] b);
        return (int'(b[23:20]) * 10 + int'(b[19:16])) * 6000 +
               (int'(b[15:12]) * 10 + int'(b[11:8])) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_hold = 0;
        for (int k = 0; k < 2; k++) begin
            m_cs[k]   = 0;
            m_pre[k]  = 0;
            m_ovf[k]  = 0;
            m_tick[k] = 0;
        end
    endtask

    task automatic model_step(input bit t, input bit s, input bit c, input bit l);
        if (c) begin
            model_reset();
            return;
        end
        if (LAP && m_mode == 1 && s)
            m_hold = 0;
        else if (LAP && m_mode == 1 && l) begin
            if (!m_hold) begin
                m_snap[0] = m_cs[0];
                m_snap[1] = m_cs[1];
            end
            m_hold = !m_hold;
        end
        for (int k = 0; k < 2; k++) begin
            m_tick[k] = 0;
            if (m_mode == 1 && t) begin
                m_pre[k]++;
                if (m_pre[k] == TIC_DIV) begin
                    m_pre[k] = 0;
                    if (m_cs[k] == MAX_CS) begin
                        m_ovf[k] = 1;
                        if (k == 1) begin
                            m_cs[k]   = 0;
                            m_tick[k] = 1;
                        end
                    end else begin
                        m_cs[k]++;
                        m_tick[k] = 1;
                    end
                end
            end
        end
        if (s) m_mode = (m_mode == 1) ? 2 : 1;
    endtask

    function automatic logic [23:0] exp_time(input int k);
        return m_hold ? to_bcd(m_snap[k]) : to_bcd(m_cs[k]);
    endfunction

    task automatic check_all();
        chk("s_time", sw_s.o_time_bcd, exp_time(0));
        chk("s_running", 24'(sw_s.o_running), 24'(m_mode == 1));
        chk("s_ovf", 24'(sw_s.o_ovf), 24'(m_ovf[0]));
        chk("s_cs_tick", 24'(sw_s.o_cs_tick), 24'(m_tick[0]));
        chk("w_time", sw_w.o_time_bcd, exp_time(1));
        chk("w_running", 24'(sw_w.o_running), 24'(m_mode == 1));
        chk("w_ovf", 24'(sw_w.o_ovf), 24'(m_ovf[1]));
        chk("w_cs_tick", 24'(sw_w.o_cs_tick), 24'(m_tick[1]));
    endtask

    task automatic cyc(input bit r, input bit t, input bit s, input bit c, input bit l);
        rst               = r;
        sw_s.i_tic        = t;
        sw_s.i_start_stop = s;
        sw_s.i_clear      = c;
        sw_s.i_lap        = l;
        sw_w.i_tic        = t;
        sw_w.i_start_stop = s;
        sw_w.i_clear      = c;
        sw_w.i_lap        = l;
        @(posedge clk);
        if (!r) model_reset();
        else model_step(t, s, c, l);
        #1;
        check_all();
        if (sw_s.o_cs_tick) n_ticks++;
    endtask

    task automatic tics(input int n);
        repeat (n) cyc(1, 1, 0, 0, 0);
    endtask

    // Only valid outside RUN: the held digit registers re-load their own forced value.
    task automatic preload(input logic [23:0] v);
        pv = v;
        m_cs[0] = to_cs(v);
        m_cs[1] = to_cs(v);
        force dut_s.u_cs_u.r_q  = pv[3:0];
        force dut_s.u_cs_t.r_q  = pv[7:4];
        force dut_s.u_sec_u.r_q = pv[11:8];
        force dut_s.u_sec_t.r_q = pv[15:12];
        force dut_s.u_min_u.r_q = pv[19:16];
        force dut_s.u_min_t.r_q = pv[23:20];
        force dut_w.u_cs_u.r_q  = pv[3:0];
        force dut_w.u_cs_t.r_q  = pv[7:4];
        force dut_w.u_sec_u.r_q = pv[11:8];
        force dut_w.u_sec_t.r_q = pv[15:12];
        force dut_w.u_min_u.r_q = pv[19:16];
        force dut_w.u_min_t.r_q = pv[23:20];
        cyc(1, 0, 0, 0, 0);
        release dut_s.u_cs_u.r_q;
        release dut_s.u_cs_t.r_q;
        release dut_s.u_sec_u.r_q;
        release dut_s.u_sec_t.r_q;
        release dut_s.u_min_u.r_q;
        release dut_s.u_min_t.r_q;
        release dut_w.u_cs_u.r_q;
        release dut_w.u_cs_t.r_q;
        release dut_w.u_sec_u.r_q;
        release dut_w.u_sec_t.r_q;
        release dut_w.u_min_u.r_q;
        release dut_w.u_min_t.r_q;
        cyc(1, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) cyc(0, ($urandom % 2) == 0, ($urandom % 2) == 0, 1'b0, ($urandom % 2) == 0);
        chk("rst_time", sw_s.o_time_bcd, 24'h000000);
        // start with a coincident tic, which must not be counted
        cyc(1, 1, 1, 0, 0);
        n_ticks = 0;
        tics(20);
        chk("t1_time", sw_s.o_time_bcd, 24'h000002);
        chk("t1_ticks", 24'(n_ticks), 24'd2);
        chk("t1_running", 24'(sw_s.o_running), 24'd1);
        // stop with a coincident tic, which must be counted
        cyc(1, 1, 1, 0, 0);
        tics(50);
        chk("t2_paused_time", sw_s.o_time_bcd, 24'h000002);
        chk("t2_running", 24'(sw_s.o_running), 24'd0);
        cyc(1, 0, 1, 0, 0);
        tics(10);
        chk("t2_resumed_time", sw_s.o_time_bcd, 24'h000003);
        cyc(1, 0, 1, 0, 0);
        preload(24'h005999);
        cyc(1, 0, 1, 0, 0);
        tics(TIC_DIV - m_pre[0]);
        chk("t5_rollover", sw_s.o_time_bcd, 24'h010000);
        chk("t5_cs_tick", 24'(sw_s.o_cs_tick), 24'd1);
        cyc(1, 0, 1, 0, 0);
        preload(24'h995999);
        cyc(1, 0, 1, 0, 0);
        tics(TIC_DIV - m_pre[0]);
        chk("t3_sat_time", sw_s.o_time_bcd, 24'h995999);
        chk("t3_sat_ovf", 24'(sw_s.o_ovf), 24'd1);
        chk("t3_sat_tick", 24'(sw_s.o_cs_tick), 24'd0);
        chk("t3_wrap_time", sw_w.o_time_bcd, 24'h000000);
        chk("t3_wrap_ovf", 24'(sw_w.o_ovf), 24'd1);
        tics(TIC_DIV);
        chk("t3_sat_hold", sw_s.o_time_bcd, 24'h995999);
        chk("t3_sat_running", 24'(sw_s.o_running), 24'd1);
        chk("t3_wrap_after", sw_w.o_time_bcd, 24'h000001);
        chk("t3_wrap_ovf_sticky", 24'(sw_w.o_ovf), 24'd1);
        cyc(1, 1, 1, 1, 0);
        chk("t4_time", sw_s.o_time_bcd, 24'h000000);
        chk("t4_ovf", 24'(sw_s.o_ovf), 24'd0);
        chk("t4_running", 24'(sw_s.o_running), 24'd0);
        for (int i = 0; i < 4000; i++) begin
            if (i % 1000 == 500 && m_mode != 1)
                preload(to_bcd(MAX_CS - int'($urandom % 50)));
            cyc(($urandom % 500) != 0, ($urandom % 2) == 0, ($urandom % 40) == 0,
                ($urandom % 400) == 0, ($urandom % 25) == 0);
        end
`ifdef STOPWATCH_LAP_HOLD_EN
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 1, 0, 0);
        tics(1000);
        chk("t6_live", sw_s.o_time_bcd, 24'h000100);
        cyc(1, 0, 0, 0, 1);
        tics(100);
        chk("t6_hold", sw_s.o_time_bcd, 24'h000100);
        cyc(1, 0, 0, 0, 1);
        chk("t6_release", sw_s.o_time_bcd, 24'h000110);
        cyc(1, 0, 0, 0, 1);
        tics(30);
        cyc(0, 1, 0, 0, 1);
        chk("t6_rst_time", sw_s.o_time_bcd, 24'h000000);
        chk("t6_rst_running", 24'(sw_s.o_running), 24'd0);
`endif
        cyc(0, 1, 1, 0, 0);
        chk("end_rst_time", sw_w.o_time_bcd, 24'h000000);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
